// File: rtl/iq_issue_ctrl_pkg.sv
// Shared types for the issue scheduler: window entry layout, FU classes, scoreboard entry.
// The decode helpers are the only place that knows where fields sit inside dec_inst.
package iq_issue_ctrl_pkg;

  localparam int EXT_COUNT = 4;
  localparam int ALU_PORTS = 2;
  localparam int MEM_PORTS = 1;
  localparam int WB_COUNT  = 3;
  localparam int NREGS     = 32;
  localparam int REG_W     = 5;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [1:0][REG_W-1:0] src_pair_t;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_MEM = 1'b1
  } fu_class_t;

  typedef struct packed {
    fu_class_t fu;
    reg_idx_t  dst;
    reg_idx_t  src1;
    reg_idx_t  src0;
  } dec_inst_t;

  typedef struct packed {
    logic      stream;
    dec_inst_t dec_inst;
  } iq_entry_t;

  typedef struct packed {
    logic busy;
    logic stream;
  } sb_entry_t;

  function automatic src_pair_t src_regs(input dec_inst_t d);
    return {d.src1, d.src0};
  endfunction

  function automatic reg_idx_t dst_reg(input dec_inst_t d);
    return d.dst;
  endfunction

  function automatic fu_class_t fu_class(input dec_inst_t d);
    return d.fu;
  endfunction

endpackage

// File: rtl/iq_issue_ctrl_if.sv
// Window, control, writeback and issue-port bundle between queue, scheduler and FUs.
// slave is the scheduler side; master is the environment driving the window and ports.
interface iq_issue_ctrl_if;
  import iq_issue_ctrl_pkg::*;

  logic [EXT_COUNT-1:0]                 win_valid;
  iq_entry_t [EXT_COUNT-1:0]            win_entry;
  logic                                 issue_enable;
  logic                                 flush;
  logic                                 flush_stream;
  logic [ALU_PORTS-1:0]                 alu_ready;
  logic [MEM_PORTS-1:0]                 mem_ready;
  logic [WB_COUNT-1:0]                  wb_valid;
  reg_idx_t [WB_COUNT-1:0]              wb_reg;
  logic [EXT_COUNT-1:0]                 ext_consumed;
  logic                                 ext_enable;
  logic [ALU_PORTS-1:0]                 alu_valid;
  iq_entry_t [ALU_PORTS-1:0]            alu_op;
  logic [MEM_PORTS-1:0]                 mem_valid;
  iq_entry_t [MEM_PORTS-1:0]            mem_op;
  logic [NREGS-1:0]                     sb_busy;

  modport master (
    output win_valid, win_entry, issue_enable, flush, flush_stream,
           alu_ready, mem_ready, wb_valid, wb_reg,
    input  ext_consumed, ext_enable, alu_valid, alu_op, mem_valid, mem_op, sb_busy
  );

  modport slave (
    input  win_valid, win_entry, issue_enable, flush, flush_stream,
           alu_ready, mem_ready, wb_valid, wb_reg,
    output ext_consumed, ext_enable, alu_valid, alu_op, mem_valid, mem_op, sb_busy
  );

endinterface

// File: rtl/iss_scoreboard.sv
// Register busy/stream scoreboard: issue sets (wins over clear), writeback and stream flush clear.
// reg_rdy is combinational and folds in same-cycle writeback; state updates at the clock edge.
module iss_scoreboard
  import iq_issue_ctrl_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [EXT_COUNT-1:0]     set_vld,
  input  reg_idx_t [EXT_COUNT-1:0] set_reg,
  input  logic [EXT_COUNT-1:0]     set_stream,
  input  logic [WB_COUNT-1:0]      wb_valid,
  input  reg_idx_t [WB_COUNT-1:0]  wb_reg,
  input  logic                     flush,
  input  logic                     flush_stream,
  output logic [NREGS-1:0]         reg_rdy,
  output logic [NREGS-1:0]         busy
);

  sb_entry_t [NREGS-1:0] sb_q, sb_d;
  logic [NREGS-1:0]      wb_hit;

  always_comb begin
    wb_hit = '0;
    for (int w = 0; w < WB_COUNT; w++) begin
      if (wb_valid[w]) wb_hit[wb_reg[w]] = 1'b1;
    end

    sb_d = sb_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush && (sb_q[r].stream == flush_stream)) sb_d[r].busy = 1'b0;
      if (wb_hit[r]) sb_d[r].busy = 1'b0;
    end
    // Applied after the clears so a same-cycle set on the same register wins.
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (set_vld[i] && (set_reg[i] != '0)) begin
        sb_d[set_reg[i]].busy   = 1'b1;
        sb_d[set_reg[i]].stream = set_stream[i];
      end
    end
    sb_d[0] = '0;

    for (int r = 0; r < NREGS; r++) begin
      busy[r]    = sb_q[r].busy;
      reg_rdy[r] = !sb_q[r].busy || wb_hit[r];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

endmodule

// File: rtl/iq_issue_ctrl.sv
// Issue scheduler: combinational hazard check and priority port binding over the window head,
// registered ALU/MEM issue (latency 1); ready=0 ports are skipped, unbound slots stay queued.
module iq_issue_ctrl
  import iq_issue_ctrl_pkg::*;
(
  input logic            clock,
  input logic            reset,
  iq_issue_ctrl_if.slave bus
);

  src_pair_t [EXT_COUNT-1:0] src_w;
  reg_idx_t [EXT_COUNT-1:0]  dst_w;
  fu_class_t                 cls_w [EXT_COUNT];
  logic [EXT_COUNT-1:0]      stream_w;
  logic [EXT_COUNT-1:0]      elig;
  logic [EXT_COUNT-1:0]      bound;
  logic [NREGS-1:0]          reg_rdy;
  logic [NREGS-1:0]          busy;
  logic                      issue_ok;

  logic [ALU_PORTS-1:0]      alu_valid_d, alu_valid_q;
  iq_entry_t [ALU_PORTS-1:0] alu_op_d, alu_op_q;
  logic [MEM_PORTS-1:0]      mem_valid_d, mem_valid_q;
  iq_entry_t [MEM_PORTS-1:0] mem_op_d, mem_op_q;

  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++) begin
      src_w[i]    = src_regs(bus.win_entry[i].dec_inst);
      dst_w[i]    = dst_reg(bus.win_entry[i].dec_inst);
      cls_w[i]    = fu_class(bus.win_entry[i].dec_inst);
      stream_w[i] = bus.win_entry[i].stream;
    end
  end

  always_comb begin
    issue_ok    = bus.issue_enable && !bus.flush && !reset;
    elig        = '0;
    bound       = '0;
    alu_valid_d = '0;
    alu_op_d    = '0;
    mem_valid_d = '0;
    mem_op_d    = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      elig[i] = issue_ok && bus.win_valid[i]
              && reg_rdy[src_w[i][0]] && reg_rdy[src_w[i][1]]
              && ((dst_w[i] == '0) || !busy[dst_w[i]]);
      // Register 0 never creates a dependency, so only nonzero destinations are compared.
      for (int j = 0; j < i; j++) begin
        if (bus.win_valid[j]) begin
          if ((dst_w[j] != '0) && ((dst_w[j] == src_w[i][0]) || (dst_w[j] == src_w[i][1])
                                   || (dst_w[j] == dst_w[i])))
            elig[i] = 1'b0;
          if ((dst_w[i] != '0) && ((src_w[j][0] == dst_w[i]) || (src_w[j][1] == dst_w[i])))
            elig[i] = 1'b0;
          if ((cls_w[i] == FU_MEM) && (cls_w[j] == FU_MEM) && !bound[j])
            elig[i] = 1'b0;
        end
      end
      if (elig[i] && (cls_w[i] == FU_ALU)) begin
        for (int p = 0; p < ALU_PORTS; p++) begin
          if (!bound[i] && bus.alu_ready[p] && !alu_valid_d[p]) begin
            alu_valid_d[p] = 1'b1;
            alu_op_d[p]    = bus.win_entry[i];
            bound[i]       = 1'b1;
          end
        end
      end else if (elig[i]) begin
        for (int p = 0; p < MEM_PORTS; p++) begin
          if (!bound[i] && bus.mem_ready[p] && !mem_valid_d[p]) begin
            mem_valid_d[p] = 1'b1;
            mem_op_d[p]    = bus.win_entry[i];
            bound[i]       = 1'b1;
          end
        end
      end
    end
  end

  iss_scoreboard u_sb (
    .clock        (clock),
    .reset        (reset),
    .set_vld      (bound),
    .set_reg      (dst_w),
    .set_stream   (stream_w),
    .wb_valid     (bus.wb_valid),
    .wb_reg       (bus.wb_reg),
    .flush        (bus.flush),
    .flush_stream (bus.flush_stream),
    .reg_rdy      (reg_rdy),
    .busy         (busy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_valid_q <= '0;
      alu_op_q    <= '0;
      mem_valid_q <= '0;
      mem_op_q    <= '0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      mem_valid_q <= mem_valid_d;
      mem_op_q    <= mem_op_d;
    end
  end

  assign bus.ext_consumed = bound;
  assign bus.ext_enable   = |bound;
  assign bus.alu_valid    = alu_valid_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_op       = mem_op_q;
  assign bus.sb_busy      = busy;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Directed bench for iq_issue_ctrl: stimulus queues per-cycle and per-issue expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_iq_issue_ctrl;
  import iq_issue_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;

  iq_issue_ctrl_if bus();

  iq_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string                tag;
    logic [EXT_COUNT-1:0] cons;
    logic [NREGS-1:0]     mask;
    logic [NREGS-1:0]     val;
  } cyc_exp_t;

  typedef struct {
    string                     tag;
    logic [ALU_PORTS-1:0]      av;
    iq_entry_t [ALU_PORTS-1:0] ao;
    logic [MEM_PORTS-1:0]      mv;
    iq_entry_t [MEM_PORTS-1:0] mo;
  } iss_exp_t;

  cyc_exp_t cq[$];
  iss_exp_t iq[$];
  int checks = 0;
  int errors = 0;
  iq_entry_t z = '0;
  localparam logic [NREGS-1:0] ALL = '1;
  localparam logic [NREGS-1:0] NONE = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic iq_entry_t mk(input fu_class_t fu, input int d, input int s0, input int s1,
                                   input logic st);
    iq_entry_t e;
    e.stream        = st;
    e.dec_inst.fu   = fu;
    e.dec_inst.dst  = reg_idx_t'(d);
    e.dec_inst.src0 = reg_idx_t'(s0);
    e.dec_inst.src1 = reg_idx_t'(s1);
    return e;
  endfunction

  function automatic logic [NREGS-1:0] bm(input int r);
    logic [NREGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.win_valid    = '0;
    bus.win_entry    = '0;
    bus.wb_valid     = '0;
    bus.wb_reg       = '0;
    bus.flush        = 1'b0;
    bus.flush_stream = 1'b0;
  endtask

  task automatic win(input logic [3:0] v, input iq_entry_t s0, input iq_entry_t s1,
                     input iq_entry_t s2, input iq_entry_t s3);
    bus.win_valid    = v;
    bus.win_entry[0] = s0;
    bus.win_entry[1] = s1;
    bus.win_entry[2] = s2;
    bus.win_entry[3] = s3;
  endtask

  task automatic wbk(input logic [2:0] v, input int r0, input int r1, input int r2);
    bus.wb_valid  = v;
    bus.wb_reg[0] = reg_idx_t'(r0);
    bus.wb_reg[1] = reg_idx_t'(r1);
    bus.wb_reg[2] = reg_idx_t'(r2);
  endtask

  task automatic expc(input string tag, input logic [3:0] cons, input logic [NREGS-1:0] mask,
                      input logic [NREGS-1:0] val);
    cyc_exp_t c;
    c.tag  = tag;
    c.cons = cons;
    c.mask = mask;
    c.val  = val;
    cq.push_back(c);
  endtask

  task automatic expi(input string tag, input logic [1:0] av, input iq_entry_t a0,
                      input iq_entry_t a1, input logic mv, input iq_entry_t m0);
    iss_exp_t e;
    e.tag   = tag;
    e.av    = av;
    e.ao[0] = a0;
    e.ao[1] = a1;
    e.mv[0] = mv;
    e.mo[0] = m0;
    iq.push_back(e);
  endtask

  // Monitor: per-cycle window/scoreboard expectations and issue-port expectations.
  initial begin
    cyc_exp_t c;
    iss_exp_t e;
    forever begin
      @(negedge clock);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk({c.tag, " consumed"}, 64'(bus.ext_consumed), 64'(c.cons));
        chk({c.tag, " enable"}, 64'(bus.ext_enable), 64'(|c.cons));
        if (c.mask != '0) chk({c.tag, " sb_busy"}, 64'(bus.sb_busy & c.mask), 64'(c.val));
      end
      if ((bus.alu_valid != '0) || (bus.mem_valid != '0)) begin
        if (iq.size() == 0) begin
          chk("unexpected_issue", 64'({bus.alu_valid, bus.mem_valid}), 64'(0));
        end else begin
          e = iq.pop_front();
          chk({e.tag, " alu_valid"}, 64'(bus.alu_valid), 64'(e.av));
          chk({e.tag, " mem_valid"}, 64'(bus.mem_valid), 64'(e.mv));
          for (int p = 0; p < ALU_PORTS; p++)
            if (e.av[p]) chk($sformatf("%s alu_op%0d", e.tag, p), 64'(bus.alu_op[p]), 64'(e.ao[p]));
          for (int p = 0; p < MEM_PORTS; p++)
            if (e.mv[p]) chk($sformatf("%s mem_op%0d", e.tag, p), 64'(bus.mem_op[p]), 64'(e.mo[p]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.issue_enable = 1'b1;
    bus.alu_ready    = '1;
    bus.mem_ready    = '1;
    idle();

    // Reset state, with a valid slot that must not be consumed.
    tick(); win(4'b0001, mk(FU_ALU, 1, 2, 0, 1'b0), z, z, z);
    expc("reset", 4'b0000, ALL, NONE);
    tick(); reset = 1'b0; idle();
    expc("post_reset", 4'b0000, ALL, NONE);

    // Independent ops: two ALU ports and one MEM port fill, slot 3 waits.
    tick(); win(4'b1111, mk(FU_ALU, 1, 2, 0, 1'b0), mk(FU_ALU, 3, 4, 0, 1'b0),
                mk(FU_MEM, 5, 20, 0, 1'b0), mk(FU_ALU, 6, 7, 0, 1'b0));
    expc("indep", 4'b0111, NONE, NONE);
    expi("indep", 2'b11, mk(FU_ALU, 1, 2, 0, 1'b0), mk(FU_ALU, 3, 4, 0, 1'b0),
         1'b1, mk(FU_MEM, 5, 20, 0, 1'b0));
    tick(); win(4'b0001, mk(FU_ALU, 6, 7, 0, 1'b0), z, z, z);
    expc("indep_tail", 4'b0001, bm(1) | bm(3) | bm(5) | bm(6), bm(1) | bm(3) | bm(5));
    expi("indep_tail", 2'b01, mk(FU_ALU, 6, 7, 0, 1'b0), z, 1'b0, z);
    tick(); idle(); wbk(3'b111, 1, 3, 5);
    expc("indep_wb", 4'b0000, bm(1) | bm(3) | bm(5) | bm(6), bm(1) | bm(3) | bm(5) | bm(6));
    tick(); idle(); wbk(3'b001, 6, 0, 0);
    expc("indep_wb2", 4'b0000, bm(1) | bm(3) | bm(5) | bm(6), bm(6));
    tick(); idle();
    expc("indep_clean", 4'b0000, ALL, NONE);

    // RAW inside the window, then release via writeback bypass.
    tick(); win(4'b0011, mk(FU_ALU, 8, 2, 0, 1'b0), mk(FU_ALU, 9, 8, 0, 1'b0), z, z);
    expc("raw", 4'b0001, ALL, NONE);
    expi("raw", 2'b01, mk(FU_ALU, 8, 2, 0, 1'b0), z, 1'b0, z);
    tick(); win(4'b0001, mk(FU_ALU, 9, 8, 0, 1'b0), z, z, z);
    expc("raw_stall1", 4'b0000, bm(8), bm(8));
    tick();
    expc("raw_stall2", 4'b0000, bm(8), bm(8));
    tick(); wbk(3'b100, 0, 0, 8);
    expc("raw_bypass", 4'b0001, bm(8), bm(8));
    expi("raw_bypass", 2'b01, mk(FU_ALU, 9, 8, 0, 1'b0), z, 1'b0, z);
    tick(); idle();
    expc("raw_after", 4'b0000, bm(8) | bm(9), bm(9));
    tick(); idle(); wbk(3'b010, 0, 9, 0);
    expc("raw_wb9", 4'b0000, bm(9), bm(9));
    tick(); idle();
    expc("raw_clean", 4'b0000, ALL, NONE);

    // Memory ordering: younger load waits behind a blocked older load.
    tick(); win(4'b0001, mk(FU_ALU, 10, 2, 0, 1'b0), z, z, z);
    expc("mem_prod", 4'b0001, ALL, NONE);
    expi("mem_prod", 2'b01, mk(FU_ALU, 10, 2, 0, 1'b0), z, 1'b0, z);
    tick(); win(4'b0011, mk(FU_MEM, 11, 10, 0, 1'b0), mk(FU_MEM, 15, 21, 0, 1'b0), z, z);
    expc("mem_block1", 4'b0000, bm(10), bm(10));
    tick();
    expc("mem_block2", 4'b0000, bm(10), bm(10));
    tick(); wbk(3'b001, 10, 0, 0);
    expc("mem_release", 4'b0001, bm(10), bm(10));
    expi("mem_release", 2'b00, z, z, 1'b1, mk(FU_MEM, 11, 10, 0, 1'b0));
    tick(); idle(); win(4'b0001, mk(FU_MEM, 15, 21, 0, 1'b0), z, z, z);
    expc("mem_second", 4'b0001, bm(10) | bm(11), bm(11));
    expi("mem_second", 2'b00, z, z, 1'b1, mk(FU_MEM, 15, 21, 0, 1'b0));
    tick(); idle(); wbk(3'b011, 11, 15, 0);
    expc("mem_wb", 4'b0000, bm(11) | bm(15), bm(11) | bm(15));
    tick(); idle();
    expc("mem_clean", 4'b0000, ALL, NONE);

    // Flush of stream 1 only.
    tick(); win(4'b0011, mk(FU_ALU, 12, 2, 0, 1'b1), mk(FU_ALU, 13, 3, 0, 1'b0), z, z);
    expc("fl_setup", 4'b0011, ALL, NONE);
    expi("fl_setup", 2'b11, mk(FU_ALU, 12, 2, 0, 1'b1), mk(FU_ALU, 13, 3, 0, 1'b0), 1'b0, z);
    tick(); win(4'b0001, mk(FU_ALU, 16, 17, 0, 1'b0), z, z, z);
    bus.flush = 1'b1; bus.flush_stream = 1'b1;
    expc("fl_cycle", 4'b0000, bm(12) | bm(13), bm(12) | bm(13));
    tick(); idle();
    expc("fl_after", 4'b0000, bm(12) | bm(13) | bm(16), bm(13));
    tick(); idle(); wbk(3'b001, 13, 0, 0);
    expc("fl_wb", 4'b0000, bm(13), bm(13));
    tick(); idle();
    expc("fl_clean", 4'b0000, ALL, NONE);

    // Set/clear collision on r14, and a write to r0.
    tick(); win(4'b0001, mk(FU_ALU, 14, 2, 0, 1'b0), z, z, z); wbk(3'b001, 14, 0, 0);
    expc("coll", 4'b0001, NONE, NONE);
    expi("coll", 2'b01, mk(FU_ALU, 14, 2, 0, 1'b0), z, 1'b0, z);
    tick(); idle(); win(4'b0001, mk(FU_ALU, 0, 3, 0, 1'b0), z, z, z);
    expc("r0_issue", 4'b0001, bm(14), bm(14));
    expi("r0_issue", 2'b01, mk(FU_ALU, 0, 3, 0, 1'b0), z, 1'b0, z);
    tick(); idle();
    expc("r0_after", 4'b0000, bm(0) | bm(14), bm(14));
    tick(); idle(); wbk(3'b001, 14, 0, 0);
    expc("coll_wb", 4'b0000, bm(14), bm(14));

    // ALU port 0 not ready: slot 0 takes port 1, slot 1 has no port.
    tick(); idle(); bus.alu_ready = 2'b10;
    win(4'b0011, mk(FU_ALU, 17, 2, 0, 1'b0), mk(FU_ALU, 18, 3, 0, 1'b0), z, z);
    expc("rdy_part", 4'b0001, ALL, NONE);
    expi("rdy_part", 2'b10, z, mk(FU_ALU, 17, 2, 0, 1'b0), 1'b0, z);
    tick(); bus.alu_ready = 2'b11; win(4'b0001, mk(FU_ALU, 18, 3, 0, 1'b0), z, z, z);
    expc("rdy_rest", 4'b0001, bm(17), bm(17));
    expi("rdy_rest", 2'b01, mk(FU_ALU, 18, 3, 0, 1'b0), z, 1'b0, z);
    tick(); idle(); wbk(3'b011, 17, 18, 0);
    expc("rdy_wb", 4'b0000, bm(17) | bm(18), bm(17) | bm(18));

    // Issue disabled.
    tick(); idle(); bus.issue_enable = 1'b0; win(4'b0001, mk(FU_ALU, 19, 2, 0, 1'b0), z, z, z);
    expc("issue_off", 4'b0000, ALL, NONE);
    tick(); idle(); bus.issue_enable = 1'b1;
    expc("issue_on", 4'b0000, ALL, NONE);

    // Reset with two ops in flight.
    tick(); win(4'b0011, mk(FU_ALU, 20, 2, 0, 1'b0), mk(FU_MEM, 21, 3, 0, 1'b0), z, z);
    expc("rst_setup", 4'b0011, ALL, NONE);
    expi("rst_setup", 2'b01, mk(FU_ALU, 20, 2, 0, 1'b0), z, 1'b1, mk(FU_MEM, 21, 3, 0, 1'b0));
    tick(); reset = 1'b1; win(4'b0001, mk(FU_ALU, 22, 2, 0, 1'b0), z, z, z);
    expc("rst_cycle", 4'b0000, bm(20) | bm(21), bm(20) | bm(21));
    tick(); reset = 1'b0; idle();
    expc("rst_after", 4'b0000, ALL, NONE);
    tick(); idle();
    expc("rst_idle", 4'b0000, ALL, NONE);

    tick(); tick(); tick();
    chk("cycle_queue_drained", 64'(cq.size()), 64'(0));
    chk("issue_queue_drained", 64'(iq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
